// File: rtl/blowfish128_round_ctrl.sv
// Blowfish-128 Feistel round sequencer: walks the P-array, drives the F-function
// handshake and applies the final swap undo and output whitening.
module blowfish128_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int PAW    = 5
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic             Decrypt,
  input  logic [127:0]     DataIn,
  output logic [PAW-1:0]   PAddr,
  input  logic [63:0]      PKey,
  output logic             FEnable,
  output logic [63:0]      FX,
  input  logic [63:0]      FY,
  input  logic             FValid,
  output logic [127:0]     DataOut,
  output logic             Done,
  output logic             Busy
);

  // state | meaning
  // IDLE  | waiting for Start
  // XORP  | L ^= P[round], arm F for one call
  // FCALL | F running; on FValid fold result into R and swap
  // FIN_R | undo last swap, whiten R with P[16] (P[1] decrypt)
  // FIN_L | whiten L with P[17] (P[0] decrypt), publish result
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    XORP  = 3'd1,
    FCALL = 3'd2,
    FIN_R = 3'd3,
    FIN_L = 3'd4
  } state_e;

  localparam logic [3:0]     LAST_RND = 4'(ROUNDS - 1);
  localparam logic [PAW-1:0] P_LAST   = PAW'(ROUNDS + 1);
  localparam logic [PAW-1:0] P_PRE    = PAW'(ROUNDS);

  state_e         state_q, state_d;
  logic [63:0]    l_q, l_d;
  logic [63:0]    r_q, r_d;
  logic [3:0]     round_q, round_d;
  logic           dec_q, dec_d;
  logic           fen_q, fen_d;
  logic           done_q, done_d;
  logic [127:0]   dout_q, dout_d;
  logic [PAW-1:0] paddr;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      fen_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      fen_q   <= fen_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    round_d = round_q;
    dec_d   = dec_q;
    fen_d   = 1'b0;
    done_d  = 1'b0;
    dout_d  = dout_q;
    paddr   = '0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          l_d     = DataIn[127:64];
          r_d     = DataIn[63:0];
          dec_d   = Decrypt;
          round_d = '0;
          state_d = XORP;
        end
      end
      XORP: begin
        paddr   = dec_q ? (P_LAST - PAW'(round_q)) : PAW'(round_q);
        l_d     = l_q ^ PKey;
        fen_d   = 1'b1;
        state_d = FCALL;
      end
      FCALL: begin
        if (FValid) begin
          l_d     = r_q ^ FY;
          r_d     = l_q;
          round_d = round_q + 4'd1;
          state_d = (round_q == LAST_RND) ? FIN_R : XORP;
        end else begin
          fen_d = 1'b1;
        end
      end
      FIN_R: begin
        paddr   = dec_q ? PAW'(1) : P_PRE;
        l_d     = r_q;
        r_d     = l_q ^ PKey;
        state_d = FIN_L;
      end
      FIN_L: begin
        paddr   = dec_q ? '0 : P_LAST;
        dout_d  = {l_q ^ PKey, r_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign PAddr   = paddr;
  assign FEnable = fen_q;
  assign FX      = l_q;
  assign DataOut = dout_q;
  assign Done    = done_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_blowfish128_round_ctrl.sv
// Directed/random bench for blowfish128_round_ctrl with a behavioural F block
// and a plain-arithmetic Blowfish reference model.
module tb_blowfish128_round_ctrl;

  logic         Clk = 1'b0;
  logic         RstN;
  logic         Start;
  logic         Decrypt;
  logic [127:0] DataIn;
  logic [4:0]   PAddr;
  logic [63:0]  PKey;
  logic         FEnable;
  logic [63:0]  FX;
  logic [63:0]  FY;
  logic         FValid;
  logic [127:0] DataOut;
  logic         Done;
  logic         Busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] p_arr [0:17];
  logic [7:0]  f_lat;
  logic [7:0]  f_cnt;
  logic        f_zero;
  logic [63:0] f_key;
  logic        f_inj;
  logic [63:0] junk;

  always #5 Clk = ~Clk;

  blowfish128_round_ctrl dut (
    .Clk(Clk), .RstN(RstN), .Start(Start), .Decrypt(Decrypt), .DataIn(DataIn),
    .PAddr(PAddr), .PKey(PKey), .FEnable(FEnable), .FX(FX), .FY(FY),
    .FValid(FValid), .DataOut(DataOut), .Done(Done), .Busy(Busy)
  );

  function automatic logic [63:0] fmix(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] t;
    t = x ^ {x[40:0], x[63:41]};
    t = t * 64'h9E3779B97F4A7C15;
    return t ^ (t >> 31) ^ k;
  endfunction

  // F block: answers on the f_lat-th enabled cycle, cleared whenever FEnable is low
  always @(posedge Clk or negedge RstN) begin
    if (!RstN)        f_cnt <= 8'd0;
    else if (!FEnable) f_cnt <= 8'd0;
    else              f_cnt <= f_cnt + 8'd1;
  end

  always_comb begin
    FValid = (FEnable && (f_cnt == f_lat - 8'd1)) || (!FEnable && f_inj);
    FY     = FEnable ? (f_zero ? 64'd0 : fmix(FX, f_key)) : junk;
    PKey   = (PAddr < 5'd18) ? p_arr[PAddr] : 64'd0;
  end

  function automatic logic [127:0] model(input logic [127:0] din, input logic dec);
    logic [63:0] xl, xr, t;
    int idx;
    xl = din[127:64];
    xr = din[63:0];
    for (int i = 0; i < 16; i++) begin
      idx = dec ? 17 - i : i;
      xl  = xl ^ p_arr[idx];
      xr  = xr ^ (f_zero ? 64'd0 : fmix(xl, f_key));
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ p_arr[dec ? 1 : 16];
    xl = xl ^ p_arr[dec ? 0 : 17];
    return {xl, xr};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] din, input logic dec,
                           input logic [7:0] k, input bit hold_start, input bit inject,
                           input logic [127:0] exp, output logic [127:0] dout);
    logic [4:0]   trace[$];
    logic [127:0] dout0;
    int           cycles, rises, bad;
    logic         prev_fen;
    bit           stable, pa0, timeout;
    f_lat = k;
    @(negedge Clk);
    Decrypt = dec; DataIn = din; Start = 1'b1;
    dout0 = DataOut; prev_fen = 1'b0; stable = 1; pa0 = 1; timeout = 0;
    cycles = 0; rises = 0;
    while (1) begin
      @(posedge Clk); #1;
      cycles++;
      if (!hold_start) Start = 1'b0;
      DataIn = {$urandom, $urandom, $urandom, $urandom};
      Decrypt = 1'($urandom);
      if (Done) break;
      if (cycles >= 3000) begin timeout = 1; break; end
      if (Busy && !FEnable) trace.push_back(PAddr);
      if (FEnable && !prev_fen) rises++;
      if (FEnable && PAddr != 5'd0) pa0 = 0;
      if (DataOut !== dout0) stable = 0;
      prev_fen = FEnable;
      f_inj = inject ? 1'($urandom) : 1'b0;
      junk  = {$urandom, $urandom};
    end
    f_inj = 1'b0;
    Start = 1'b0;
    chk({tag, "_timeout"}, 128'(timeout), 128'(0));
    chk({tag, "_dataout"}, DataOut, exp);
    chk({tag, "_latency"}, 128'(cycles - 1), 128'(16 * (1 + int'(k)) + 2));
    chk({tag, "_busy_at_done"}, 128'(Busy), 128'(0));
    chk({tag, "_dout_stable"}, 128'(stable), 128'(1));
    chk({tag, "_fen_rises"}, 128'(rises), 128'(16));
    chk({tag, "_paddr_fcall0"}, 128'(pa0), 128'(1));
    chk({tag, "_trace_len"}, 128'(trace.size()), 128'(18));
    bad = 0;
    for (int i = 0; i < 18 && i < trace.size(); i++) begin
      int e;
      if (i < 16)       e = dec ? 17 - i : i;
      else if (i == 16) e = dec ? 1 : 16;
      else              e = dec ? 0 : 17;
      if (int'(trace[i]) != e) bad++;
    end
    chk({tag, "_paddr_trace_bad"}, 128'(bad), 128'(0));
    dout = DataOut;
    @(posedge Clk); #1;
    chk({tag, "_done_one_cycle"}, 128'(Done), 128'(0));
    chk({tag, "_idle_after"}, 128'(Busy), 128'(0));
    chk({tag, "_dout_held"}, DataOut, dout);
  endtask

  initial begin
    logic [127:0] din, ct, res, exp;
    logic [7:0]   k;
    int           w;
    RstN = 1'b0; Start = 1'b0; Decrypt = 1'b0; DataIn = '0;
    f_lat = 8'd1; f_zero = 1'b1; f_key = '0; f_inj = 1'b0; junk = '0;
    for (int i = 0; i < 18; i++) p_arr[i] = 64'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy",    128'(Busy),    128'(0));
    chk("rst_done",    128'(Done),    128'(0));
    chk("rst_fen",     128'(FEnable), 128'(0));
    chk("rst_dataout", DataOut,       128'(0));
    chk("rst_paddr",   128'(PAddr),   128'(0));
    chk("rst_fx",      128'(FX),      128'(0));
    @(negedge Clk); RstN = 1'b1;

    // FY=0, P=0: swaps cancel, final swap exchanges halves
    run_block("zero_enc", 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 8'd1, 0, 1,
              128'hFEDCBA9876543210_0123456789ABCDEF, res);

    for (int i = 0; i < 18; i++) p_arr[i] = 64'(i);
    run_block("pk_enc", 128'd0, 1'b0, 8'd1, 0, 1,
              128'h0000000000000011_0000000000000010, res);
    run_block("pk_dec_k9", 128'd0, 1'b1, 8'd9, 0, 1,
              128'h0000000000000010_0000000000000011, res);

    f_zero = 1'b0;
    for (int key = 0; key < 3; key++) begin
      for (int i = 0; i < 18; i++) p_arr[i] = {$urandom, $urandom};
      f_key = {$urandom, $urandom};
      din   = {$urandom, $urandom, $urandom, $urandom};
      k     = 8'($urandom_range(1, 4));
      exp   = model(din, 1'b0);
      run_block($sformatf("rnd%0d_enc", key), din, 1'b0, k, 0, 1, exp, ct);
      k     = 8'($urandom_range(1, 4));
      run_block($sformatf("rnd%0d_dec", key), ct, 1'b1, k, 0, 1, din, res);
    end

    // reset while F call is in progress
    f_lat = 8'd9;
    @(negedge Clk);
    Decrypt = 1'b0; DataIn = {$urandom, $urandom, $urandom, $urandom}; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    w = 0;
    while (!FEnable && w < 50) begin @(posedge Clk); #1; w++; end
    chk("mid_reach_fcall", 128'(FEnable), 128'(1));
    repeat (3) @(posedge Clk);
    #2; RstN = 1'b0; #1;
    chk("mid_rst_fen",     128'(FEnable), 128'(0));
    chk("mid_rst_busy",    128'(Busy),    128'(0));
    chk("mid_rst_done",    128'(Done),    128'(0));
    chk("mid_rst_dataout", DataOut,       128'(0));
    @(negedge Clk); RstN = 1'b1;
    din = {$urandom, $urandom, $urandom, $urandom};
    run_block("post_rst", din, 1'b0, 8'd2, 0, 0, model(din, 1'b0), res);

    // Start held high across the whole block, including the Done cycle
    din = {$urandom, $urandom, $urandom, $urandom};
    run_block("start_busy", din, 1'b1, 8'd3, 1, 1, model(din, 1'b1), res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
